dist_sensor_if: RTL and testbench
=================================

// Module: dist_sensor_if
// PURPOSE
//  Ultrasonic range-sensor front end feeding the robot controller's dist_v input.
//  Fires periodic trigger pulses and measures the returned echo pulse width.
//  Converts the width to distance units and holds the result on dist_v until the next sample.
//  Sits directly upstream of robot; its dist_v/clk/rstn connect 1:1.
// PARAMETERS
//  TRIG_CYC     10      trigger pulse length, clock cycles (>=1)
//  TICK_DIV     58      echo-high cycles per distance unit (>=1)
//  TIMEOUT_CYC  30000   max cycles waiting for echo rise, and max echo-high cycles
//  PERIOD_CYC   65000   cycles from one trigger start to the next (> TRIG_CYC+2*TIMEOUT_CYC+4)
//  MAX_DIST     16'hFFFF  value published on timeout; dist count saturates here
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rstn        in   1   asynchronous active-low reset
//  en          in   1   measurement enable (level)
//  echo        in   1   raw sensor echo, asynchronous to clk
//  trig        out  1   sensor trigger pulse
//  dist_v      out  16  last published distance, registered
//  dist_valid  out  1   one-cycle pulse, high in the cycle dist_v takes a new value
//  timeout     out  1   high while dist_v holds a timeout sample; updates with dist_v
// BEHAVIOUR
//  Reset (async, rstn=0): state IDLE, trig=0, dist_v=0 (robot reads as obstacle), dist_valid=0,
//   timeout=0, all counters and both synchroniser flops=0. Takes effect immediately, mid-op too.
//  echo passes a 2-flop synchroniser -> echo_s (2-cycle latency); all decisions use echo_s only.
//  Edges: rise = echo_s & ~echo_s_d, fall = ~echo_s & echo_s_d (echo_s_d is one extra flop).
//  Period counter pc: cleared on TRIG entry, increments every cycle, saturates at PERIOD_CYC-1.
//  FSM:
//   IDLE:     trig=0. en=1 -> TRIG.
//   TRIG:     trig=1 for exactly TRIG_CYC cycles (registered output), then -> WAIT_ECHO.
//   WAIT_ECHO: wait timer wt counts up from 0. rise -> MEASURE (prescaler=0, dcnt=0).
//             wt==TIMEOUT_CYC-1 with no rise -> publish MAX_DIST, timeout=1, -> HOLDOFF.
//             echo_s already high on entry without a rise is ignored (ends in timeout).
//   MEASURE:  each cycle echo_s=1: prescaler++; at TICK_DIV-1 prescaler wraps to 0 and
//             dcnt++ (saturating at MAX_DIST). fall -> publish dcnt, timeout=0, -> HOLDOFF.
//             echo-high cycles reaching TIMEOUT_CYC -> publish MAX_DIST, timeout=1, -> HOLDOFF.
//             Result = floor(high_cycles / TICK_DIV), where high_cycles counts echo_s-high cycles.
//   HOLDOFF:  wait until pc==PERIOD_CYC-1; then en=1 -> TRIG, en=0 -> IDLE.
//  Publish: dist_v/timeout registered on the cycle after the deciding condition; dist_valid=1
//   that same cycle only. Exactly one publish per trigger; none from IDLE.
//  Simultaneous fall and timeout in MEASURE: fall wins (real measurement published).
//  en is sampled only in IDLE and at HOLDOFF exit; dropping en mid-cycle completes the
//   current measurement (incl. publish) then returns to IDLE.
//  dist_v/timeout hold their value indefinitely between publishes.
//  Counter widths sized by $clog2 of their parameter; no wrap other than prescaler's.
// TESTING  (params TRIG_CYC=4, TICK_DIV=5, TIMEOUT_CYC=200, PERIOD_CYC=500, MAX_DIST=16'hFFFF)
//  1 rstn=0 for 3 cycles, en=1 -> dist_v=0, trig=0, dist_valid=0, timeout=0 throughout.
//  2 Release reset, en=1; echo high 50 cycles after trig -> trig high exactly 4 cycles,
//    one dist_valid pulse, dist_v=10, timeout=0; next trig 500 cycles after first.
//  3 Echo high 4 cycles -> dist_v=0, dist_valid pulses; echo high 54 cycles -> dist_v=10.
//  4 echo held low -> 200 cycles after WAIT_ECHO entry dist_v=16'hFFFF, timeout=1.
//    Echo high >200 cycles -> same result.
//  5 en=0 during MEASURE (echo 25 cycles) -> dist_v=5 published, FSM to IDLE, no further trig.
//  6 rstn pulsed low mid-MEASURE -> outputs clear asynchronously, no publish.
//    With en=1 after release: fresh trig, and the next echo measures correctly.

Source files
------------

// File: rtl/dist_sensor_if.sv
// Ultrasonic range-sensor front end: periodic trigger, echo width measurement,
// width-to-distance conversion, and registered publish of the result on dist_v.
module dist_sensor_if #(
  parameter int unsigned TRIG_CYC    = 10,
  parameter int unsigned TICK_DIV    = 58,
  parameter int unsigned TIMEOUT_CYC = 30000,
  parameter int unsigned PERIOD_CYC  = 65000,
  parameter logic [15:0] MAX_DIST    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] dist_v,
  output logic        dist_valid,
  output logic        timeout
);

  localparam int unsigned TC_W  = (TRIG_CYC    > 1) ? $clog2(TRIG_CYC)    : 1;
  localparam int unsigned PSC_W = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int unsigned WT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned PC_W  = (PERIOD_CYC  > 1) ? $clog2(PERIOD_CYC)  : 1;
  localparam int unsigned HC_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TRIG_CYC - 1);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
  localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(TIMEOUT_CYC - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PERIOD_CYC - 1);
  localparam logic [HC_W-1:0]  HC_MAX   = HC_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_HOLDOFF
  } state_t;

  state_t state, state_nxt;

  logic sync1, echo_s, echo_s_d;
  logic rise, fall;

  logic [TC_W-1:0]  tc;
  logic [WT_W-1:0]  wt;
  logic [PC_W-1:0]  pc;
  logic [PSC_W-1:0] psc;
  logic [HC_W-1:0]  hc;
  logic [15:0]      dcnt;

  logic        pub;
  logic [15:0] pub_val;
  logic        pub_to;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1    <= 1'b0;
      echo_s   <= 1'b0;
      echo_s_d <= 1'b0;
    end else begin
      sync1    <= echo;
      echo_s   <= sync1;
      echo_s_d <= echo_s;
    end
  end

  assign rise = echo_s & ~echo_s_d;
  assign fall = ~echo_s & echo_s_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Fall is tested before the high-time limit so a pulse ending exactly at the
  // limit still yields a real measurement.
  always_comb begin
    state_nxt = state;
    pub       = 1'b0;
    pub_val   = '0;
    pub_to    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_TRIG;
      end
      ST_TRIG: begin
        if (tc == TC_LAST) state_nxt = ST_WAIT_ECHO;
      end
      ST_WAIT_ECHO: begin
        if (rise) begin
          state_nxt = ST_MEASURE;
        end else if (wt == WT_LAST) begin
          pub       = 1'b1;
          pub_val   = MAX_DIST;
          pub_to    = 1'b1;
          state_nxt = ST_HOLDOFF;
        end
      end
      ST_MEASURE: begin
        if (fall) begin
          pub       = 1'b1;
          pub_val   = dcnt;
          pub_to    = 1'b0;
          state_nxt = ST_HOLDOFF;
        end else if (hc == HC_MAX) begin
          pub       = 1'b1;
          pub_val   = MAX_DIST;
          pub_to    = 1'b1;
          state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (pc == PC_LAST) state_nxt = en ? ST_TRIG : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tc <= '0;
      wt <= '0;
      pc <= '0;
    end else begin
      if (state == ST_TRIG && state_nxt == ST_TRIG) tc <= tc + 1'b1;
      else                                          tc <= '0;

      if (state == ST_WAIT_ECHO && state_nxt == ST_WAIT_ECHO) wt <= wt + 1'b1;
      else                                                    wt <= '0;

      if (state != ST_TRIG && state_nxt == ST_TRIG) pc <= '0;
      else if (pc != PC_LAST)                       pc <= pc + 1'b1;
    end
  end

  // The rising-edge cycle is itself the first echo-high cycle, so it is
  // accounted for when MEASURE is entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      psc  <= '0;
      hc   <= '0;
      dcnt <= '0;
    end else if (state == ST_WAIT_ECHO && rise) begin
      hc <= HC_W'(1);
      if (TICK_DIV == 1) begin
        psc  <= '0;
        dcnt <= (MAX_DIST != 16'd0) ? 16'd1 : 16'd0;
      end else begin
        psc  <= PSC_W'(1);
        dcnt <= '0;
      end
    end else if (state == ST_MEASURE && echo_s) begin
      if (hc != HC_MAX) hc <= hc + 1'b1;
      if (psc == PSC_LAST) begin
        psc <= '0;
        if (dcnt != MAX_DIST) dcnt <= dcnt + 1'b1;
      end else begin
        psc <= psc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trig       <= 1'b0;
      dist_v     <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      trig       <= (state_nxt == ST_TRIG);
      dist_valid <= pub;
      if (pub) begin
        dist_v  <= pub_val;
        timeout <= pub_to;
      end
    end
  end

endmodule

// File: tb/tb_dist_sensor_if.sv
// Directed bench for dist_sensor_if: expected publishes are queued as echo
// stimulus is driven and checked by a monitor whenever dist_valid pulses.
module tb_dist_sensor_if;

  logic        clk;
  logic        rstn;
  logic        en;
  logic        echo;
  logic        trig;
  logic [15:0] dist_v;
  logic        dist_valid;
  logic        timeout;

  dist_sensor_if #(
    .TRIG_CYC   (4),
    .TICK_DIV   (5),
    .TIMEOUT_CYC(200),
    .PERIOD_CYC (500),
    .MAX_DIST   (16'hFFFF)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .echo      (echo),
    .trig      (trig),
    .dist_v    (dist_v),
    .dist_valid(dist_valid),
    .timeout   (timeout)
  );

  typedef struct {
    logic [15:0] d;
    logic        t;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   valid_cnt = 0;
  int   exp_valid = 0;
  int   pub_cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dist_valid) begin
      exp_t e;
      valid_cnt++;
      pub_cyc = cyc;
      check("pub_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("dist_v", {16'd0, dist_v}, {16'd0, e.d});
        check("timeout", {31'd0, timeout}, {31'd0, e.t});
      end
    end
  end

  task automatic expect_pub(input logic [15:0] d, input logic t);
    exp_t e;
    e.d = d;
    e.t = t;
    sb.push_back(e);
    exp_valid++;
  endtask

  // Returns at the first falling edge where trig is low again.
  task automatic catch_trig(output int start, output int len);
    start = -1;
    len   = 0;
    for (int i = 0; i < 1200 && start < 0; i++) begin
      @(negedge clk);
      if (trig) start = cyc;
    end
    check("trig_seen", {31'd0, start >= 0}, 32'd1);
    if (start >= 0) begin
      len = 1;
      while (trig && len < 100) begin
        @(negedge clk);
        if (trig) len++;
      end
    end
  endtask

  task automatic echo_pulse(input int delay, input int width);
    repeat (delay) @(posedge clk);
    #1 echo = 1'b1;
    repeat (width) @(posedge clk);
    #1 echo = 1'b0;
  endtask

  task automatic wait_pub();
    for (int i = 0; i < 1000 && valid_cnt < exp_valid; i++) @(negedge clk);
    check("pub_seen", valid_cnt, exp_valid);
  endtask

  initial begin
    int t0, t1, len, c_e, trig_hits;

    // reset held with en asserted
    rstn = 1'b0;
    en   = 1'b1;
    echo = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_dist_v", {16'd0, dist_v}, 32'd0);
      check("rst_trig", {31'd0, trig}, 32'd0);
      check("rst_valid", {31'd0, dist_valid}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
    end
    rstn = 1'b1;

    // 50-cycle echo -> 10
    catch_trig(t0, len);
    check("trig_len", len, 32'd4);
    expect_pub(16'd10, 1'b0);
    echo_pulse(2, 50);
    wait_pub();

    // next trigger exactly one period later; result held meanwhile
    catch_trig(t1, len);
    check("period", t1 - t0, 32'd500);
    check("one_pub_per_trig", valid_cnt, 32'd1);
    check("hold_dist_v", {16'd0, dist_v}, 32'd10);

    // short echo -> 0
    expect_pub(16'd0, 1'b0);
    echo_pulse(3, 4);
    wait_pub();

    // 54-cycle echo -> 10
    catch_trig(t0, len);
    expect_pub(16'd10, 1'b0);
    echo_pulse(3, 54);
    wait_pub();

    // no echo: timeout 200 cycles after WAIT_ECHO entry
    catch_trig(t0, len);
    c_e = cyc;
    expect_pub(16'hFFFF, 1'b1);
    wait_pub();
    check("wait_timeout_lat", pub_cyc - c_e, 32'd200);
    repeat (50) @(negedge clk);
    check("hold_to_dist", {16'd0, dist_v}, 32'hFFFF);
    check("hold_to_flag", {31'd0, timeout}, 32'd1);

    // echo longer than the high-time limit
    catch_trig(t0, len);
    expect_pub(16'hFFFF, 1'b1);
    echo_pulse(2, 250);
    wait_pub();

    // echo exactly at the limit: fall beats timeout -> 40
    catch_trig(t0, len);
    expect_pub(16'd40, 1'b0);
    echo_pulse(2, 200);
    wait_pub();

    // en dropped mid-measurement: result still published, then idle
    catch_trig(t0, len);
    expect_pub(16'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1 echo = 1'b1;
    repeat (10) @(posedge clk);
    #1 en = 1'b0;
    repeat (15) @(posedge clk);
    #1 echo = 1'b0;
    wait_pub();
    trig_hits = 0;
    repeat (700) begin
      @(negedge clk);
      if (trig) trig_hits++;
    end
    check("idle_no_trig", trig_hits, 32'd0);
    check("idle_hold_dist", {16'd0, dist_v}, 32'd5);

    // asynchronous reset in the middle of a measurement
    en = 1'b1;
    catch_trig(t0, len);
    repeat (2) @(posedge clk);
    #1 echo = 1'b1;
    repeat (20) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("arst_dist_v", {16'd0, dist_v}, 32'd0);
    check("arst_trig", {31'd0, trig}, 32'd0);
    check("arst_valid", {31'd0, dist_valid}, 32'd0);
    check("arst_timeout", {31'd0, timeout}, 32'd0);
    echo = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("arst_no_pub", valid_cnt, exp_valid);

    // fresh trigger after reset, 37-cycle echo -> 7
    catch_trig(t0, len);
    check("trig_len_after_rst", len, 32'd4);
    expect_pub(16'd7, 1'b0);
    echo_pulse(2, 37);
    wait_pub();

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("pub_count", valid_cnt, exp_valid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
